// File: rtl/fft_cfg_pkg.sv
// Shared definitions for the FFT point-size reconfiguration sequencer:
// sequencer state encoding, point-size select codes and the select-to-points map.
package fft_cfg_pkg;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_FLUSH  = 3'd2,
        ST_CONFIG = 3'd3,
        ST_CLEAR  = 3'd4,
        ST_RESUME = 3'd5
    } recfg_state_t;

    localparam logic [1:0] SEL_128     = 2'b00;
    localparam logic [1:0] SEL_256     = 2'b01;
    localparam logic [1:0] SEL_512     = 2'b10;
    localparam logic [1:0] SEL_INVALID = 2'b11;

    localparam int CFG_W  = 24;
    localparam int RAM_AW = 8;
    localparam int RAM_DW = 16;
    localparam int FS_W   = 10;

    // Point count for a select code; the invalid code never reaches here in
    // practice and maps to the largest size.
    function automatic logic [FS_W-1:0] sel_to_points(input logic [1:0] sel);
        case (sel)
            SEL_128: return FS_W'(128);
            SEL_256: return FS_W'(256);
            SEL_512: return FS_W'(512);
            default: return FS_W'(512);
        endcase
    endfunction

endpackage

// File: rtl/recfg_ram_clear.sv
// Magnitude-RAM port A owner: clear-address counter plus write mux.
// While clear_en is high the port writes zero to consecutive addresses and
// FFT-side writes are dropped; otherwise the FFT request is passed through
// with one register stage.
module recfg_ram_clear
    import fft_cfg_pkg::*;
#(
    parameter int RAM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_en,
    output logic              clear_last,
    input  logic              fft_we_in,
    input  logic [RAM_AW-1:0] fft_addr_in,
    input  logic [RAM_DW-1:0] fft_data_in,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_data
);

    localparam int CW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;

    logic [CW-1:0] clr_addr;

    assign clear_last = clear_en && (clr_addr == CW'(RAM_DEPTH - 1));

    // Clear address walks 0..RAM_DEPTH-1 while clearing, parks at 0 otherwise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clr_addr <= '0;
        end else if (clear_en) begin
            clr_addr <= clr_addr + CW'(1);
        end else begin
            clr_addr <= '0;
        end
    end

    // Registered write port: clear writes take priority over the FFT stream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ram_we   <= 1'b0;
            ram_addr <= '0;
            ram_data <= '0;
        end else if (clear_en) begin
            ram_we   <= 1'b1;
            ram_addr <= RAM_AW'(clr_addr);
            ram_data <= '0;
        end else begin
            ram_we   <= fft_we_in;
            ram_addr <= fft_addr_in;
            ram_data <= fft_data_in;
        end
    end

endmodule

// File: rtl/fft_reconfig_sequencer.sv
// FFT point-size reconfiguration sequencer.
// Drains the in-flight frame, flushes the input buffer, resets the FFT core,
// sends the core config word over AXI-Stream, optionally zero-clears the
// magnitude RAM and then re-enables sample intake.
// Optional feature macro: RECFG_CLEAR_RAM_EN enables the RAM clear pass.
// All outputs are registered; the Moore outputs are decoded from next_state.
module fft_reconfig_sequencer
    import fft_cfg_pkg::*;
#(
    parameter logic [1:0] RESET_SEL     = 2'b10,
    parameter int         DRAIN_TIMEOUT = 1048576,
    parameter int         RST_CYCLES    = 16,
    parameter int         RAM_DEPTH     = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req_fft_sel,
    input  logic [CFG_W-1:0]  req_cfg_tdata,
    input  logic              frame_last,
    output logic              cfg_tvalid,
    output logic [CFG_W-1:0]  cfg_tdata,
    input  logic              cfg_tready,
    output logic              fft_reset,
    output logic              buf_enable,
    output logic              buf_flush,
    output logic [FS_W-1:0]   frame_size,
    input  logic              fft_we_in,
    input  logic [RAM_AW-1:0] fft_addr_in,
    input  logic [RAM_DW-1:0] fft_data_in,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [RAM_DW-1:0] ram_data,
    output logic              busy,
    output logic              reconfig_done
);

    localparam int CNT_MAX = (DRAIN_TIMEOUT > RST_CYCLES) ? DRAIN_TIMEOUT : RST_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    recfg_state_t     state, next_state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       req_sel_r;
    logic [CFG_W-1:0] req_data_r;
    logic [1:0]       act_sel;
    logic             pending;
    logic             clear_en;
    logic             clear_last;

    logic             busy_d, buf_enable_d, buf_flush_d, fft_reset_d;
    logic             cfg_tvalid_d, reconfig_done_d, latch_req;

    // A request is pending once a valid registered select differs from the
    // applied one; latching it on FLUSH entry makes the two equal again.
    assign pending = (req_sel_r != SEL_INVALID) && (req_sel_r != act_sel);

`ifdef RECFG_CLEAR_RAM_EN
    assign clear_en = (state == ST_CLEAR);
`else
    assign clear_en = 1'b0;
`endif

    // Request capture: select and config word sampled every cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_sel_r  <= RESET_SEL;
            req_data_r <= '0;
        end else begin
            req_sel_r  <= req_fft_sel;
            req_data_r <= req_cfg_tdata;
        end
    end

    // State register and per-state cycle counter (restarts on every transition)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_FLUSH;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (next_state != state) begin
                cnt <= '0;
            end else if (state == ST_DRAIN || state == ST_FLUSH) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next-state logic; frame_last wins naturally when it coincides with timeout
    always_comb begin
        next_state = state;
        case (state)
            ST_RUN: begin
                if (pending) next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (frame_last || (cnt == CNT_W'(DRAIN_TIMEOUT - 1))) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (cnt == CNT_W'(RST_CYCLES - 1)) next_state = ST_CONFIG;
            end
            ST_CONFIG: begin
`ifdef RECFG_CLEAR_RAM_EN
                if (cfg_tvalid && cfg_tready) next_state = ST_CLEAR;
`else
                if (cfg_tvalid && cfg_tready) next_state = ST_RESUME;
`endif
            end
            ST_CLEAR: begin
                if (clear_last) next_state = ST_RESUME;
            end
            ST_RESUME: begin
                next_state = pending ? ST_DRAIN : ST_RUN;
            end
            default: next_state = ST_FLUSH;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        busy_d          = (next_state != ST_RUN);
        buf_enable_d    = (next_state == ST_RUN);
        fft_reset_d     = (next_state == ST_FLUSH);
        buf_flush_d     = (next_state == ST_FLUSH) && (state != ST_FLUSH);
        cfg_tvalid_d    = (next_state == ST_CONFIG);
        reconfig_done_d = (state == ST_RESUME) && (next_state == ST_RUN);
        latch_req       = (state == ST_DRAIN) && (next_state == ST_FLUSH);
    end

    // Output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy          <= 1'b1;
            buf_enable    <= 1'b0;
            fft_reset     <= 1'b1;
            buf_flush     <= 1'b0;
            cfg_tvalid    <= 1'b0;
            reconfig_done <= 1'b0;
        end else begin
            busy          <= busy_d;
            buf_enable    <= buf_enable_d;
            fft_reset     <= fft_reset_d;
            buf_flush     <= buf_flush_d;
            cfg_tvalid    <= cfg_tvalid_d;
            reconfig_done <= reconfig_done_d;
        end
    end

    // Applied configuration: only changes on FLUSH entry, so cfg_tdata is
    // frozen for the whole CONFIG handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            act_sel    <= RESET_SEL;
            cfg_tdata  <= '0;
            frame_size <= sel_to_points(RESET_SEL);
        end else if (latch_req && (req_sel_r != SEL_INVALID)) begin
            act_sel    <= req_sel_r;
            cfg_tdata  <= req_data_r;
            frame_size <= sel_to_points(req_sel_r);
        end
    end

    recfg_ram_clear #(
        .RAM_DEPTH (RAM_DEPTH)
    ) u_ram_clear (
        .clk         (clk),
        .reset       (reset),
        .clear_en    (clear_en),
        .clear_last  (clear_last),
        .fft_we_in   (fft_we_in),
        .fft_addr_in (fft_addr_in),
        .fft_data_in (fft_data_in),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_data    (ram_data)
    );

endmodule

// File: doc/fft_reconfig_sequencer.md
# fft_reconfig_sequencer

Sequences a safe FFT point-size change between the configuration manager and the FFT datapath (input buffer, FFT core, magnitude RAM). On a new point-size request it drains the in-flight frame, flushes the buffer, resets the FFT core and performs the core's AXI config handshake. It optionally zero-clears the spectrum RAM, then re-enables sample intake. It also owns the magnitude-RAM write port, muxing FFT writes with its own clear writes.

## Interface
- `RESET_SEL`, 2'b10: point-size select applied after reset (00=128, 01=256, 10=512).
- `DRAIN_TIMEOUT`, 1048576: maximum cycles spent waiting for `frame_last`.
- `RST_CYCLES`, 16: length of the `fft_reset` assertion in cycles.
- `RAM_DEPTH`, 256: number of magnitude-RAM words to clear.

- `clk`  in  1: 100 MHz system clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req_fft_sel`  in  2: requested point-size select from the config manager.
- `req_cfg_tdata`  in  24: FFT config word matching `req_fft_sel`.
- `frame_last`  in  1: last-bin strobe from the FFT magnitude stream.
- `cfg_tvalid`  out  1: FFT config channel valid.
- `cfg_tdata`  out  24: FFT config channel data.
- `cfg_tready`  in  1: FFT config channel ready.
- `fft_reset`  out  1: active-high reset to the FFT core.
- `buf_enable`  out  1: gates sample intake in the FFT input buffer.
- `buf_flush`  out  1: one-cycle flush pulse to the input buffer.
- `frame_size`  out  10: currently applied point count (128/256/512).
- `fft_we_in`, `fft_addr_in[7:0]`, `fft_data_in[15:0]`  in: FFT-side magnitude-RAM write request.
- `ram_we`, `ram_addr[7:0]`, `ram_data[15:0]`  out: magnitude-RAM port A.
- `busy`  out  1: high in every state except RUN.
- `reconfig_done`  out  1: one-cycle pulse on return to RUN.

## Operation
- State machine states: RUN, DRAIN, FLUSH, CONFIG, CLEAR, RESUME.
- Invalid select: a `req_fft_sel` of 2'b11 is ignored and the active select is kept.
- Request capture: `req_fft_sel` and `req_cfg_tdata` are registered every cycle. A valid registered select that differs from the active select (`act_sel`) raises `pending`.
- RUN → DRAIN when `pending`. `buf_enable` drops on entry.
- DRAIN → FLUSH on `frame_last`, or when the drain counter reaches `DRAIN_TIMEOUT-1`.
- FLUSH:
  - `buf_flush` pulses in the first cycle; `fft_reset` is held for `RST_CYCLES`.
  - On entry, `act_sel` and `cfg_tdata` latch the registered request and `pending` clears.
  - Leaves to CONFIG after `RST_CYCLES`.
- CONFIG: `cfg_tvalid` stays high with `cfg_tdata` stable until `cfg_tvalid & cfg_tready`, then → CLEAR.
- CLEAR: writes 16'd0 to addresses 0..`RAM_DEPTH-1`, one per cycle, then → RESUME.
- RESUME: one cycle; pulses `reconfig_done`, raises `buf_enable`, → RUN. If `pending` was set again during the sequence, goes to DRAIN instead (no pulse).
- RAM mux: in CLEAR the port carries clear writes and `fft_we_in` is discarded. In all other states it passes the `fft_*_in` signals through, registered.
- `frame_size` = 128 << `act_sel`.

## Timing
- Reset values:
  - State = FLUSH, so the initial config is sent after reset.
  - `act_sel` = `RESET_SEL`; `frame_size` = 512 by default.
  - `cfg_tvalid`, `buf_enable`, `buf_flush`, `ram_we`, `reconfig_done` = 0.
  - `fft_reset` = 1; `busy` = 1; `ram_addr`/`ram_data`/`cfg_tdata` = 0.
- Request latency: a `req_fft_sel` change reaches DRAIN 2 cycles later (register, then compare).
- Path length from DRAIN exit to RUN: `RST_CYCLES` + handshake + `RAM_DEPTH` + 1 cycles. With default parameters and `cfg_tready` = 1 this is 16 + 1 + 256 + 1.
- Handshake rule: `cfg_tdata` must not change while `cfg_tvalid` is high.
- Outputs: all registered; RAM pass-through latency is 1 cycle.
- Simultaneous events: `frame_last` in the same cycle as the timeout counts as `frame_last`.
- Requests mid-sequence: a request arriving mid-sequence is applied only on the next pass.
- Reset mid-sequence: `reset` asserted in any state returns immediately to the reset values above.

## Configuration
- `RECFG_CLEAR_RAM_EN` defined: the CLEAR state exists as described.
- Not defined: CONFIG → RESUME directly, the RAM port is a pure pass-through, and the path length is `RST_CYCLES` + handshake + 1 cycles.

## Structure
- Shared package `fft_cfg_pkg`: state enum `recfg_state_t`, the `fft_sel` encodings, and a `sel_to_points()` function.
- One sub-module, `recfg_ram_clear`: clear-address counter plus RAM write mux.

## Test plan
- Reset release with `cfg_tready` = 1 → `fft_reset` high for 16 cycles, a `cfg_tvalid` pulse, 256 zero writes, then `reconfig_done`, `frame_size` = 512, `buf_enable` = 1.
- `req_fft_sel` 10→00 in RUN, `frame_last` 300 cycles later → `buf_enable` low during the wait, `frame_size` = 128 after the sequence, `cfg_tdata` = `req_cfg_tdata`.
- Hold `cfg_tready` = 0 for 50 cycles in CONFIG → `cfg_tvalid` high and `cfg_tdata` stable throughout; exactly one handshake.
- No `frame_last` with `DRAIN_TIMEOUT` = 100 → FLUSH entered 100 cycles after DRAIN.
- `fft_we_in` = 1 during CLEAR → `ram_data` = 0 at addresses 0..255; in RUN, `fft_addr_in` = 5, `fft_data_in` = 16'h1234 appears on `ram_*` 1 cycle later.
- New select during CLEAR, or `req_fft_sel` = 11 → re-enters DRAIN after RESUME with no `reconfig_done` pulse; select 11 causes no state change.
